wts_i2s_out: RTL and testbench

I2S transmitter that sits directly downstream of the wave table sound core's 12-bit left/right digital outputs, or the mono-mixed outputs after the mono switch. It serialises both channels into a standard Philips I2S stream (BCLK, LRCLK, SDATA) for an external audio DAC. It runs from the same 21.47727 MHz system clock and generates all I2S clocks by integer division.

---
 rtl/wts_i2s_pkg.sv | 48 ++++
 rtl/wts_i2s_bclk_gen.sv | 56 +++++
 rtl/wts_i2s_out.sv | 125 ++++++++++++
 tb/tb_wts_i2s_out.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wts_i2s_pkg.sv
// wts_i2s_pkg -- shared constants and helpers for the wave table sound I2S
// transmitter (wts_i2s_out and its bit-clock generator).
//   - frame geometry: 64 BCLK per frame, two 32-bit slots, 16-bit words
//   - LRCLK edge positions within the frame (bit counter k)
//   - LFSR seed/taps for the optional low-nibble dither (WTS_I2S_DITHER_EN)
//   - to_i2s_word(): offset-binary 12-bit sample -> left-justified 16-bit
//     two's complement word, with mute and dither nibble
package wts_i2s_pkg;

    localparam int FRAME_BITS  = 64;
    localparam int SLOT_BITS   = 32;
    localparam int WORD_BITS   = 16;
    localparam int SAMPLE_BITS = 12;

    // LRCLK goes high entering k=31 and low entering k=63, one BCLK ahead
    // of each slot's MSB. k=63 is also where both channels are latched.
    localparam logic [5:0] LR_RISE_K = 6'd31;
    localparam logic [5:0] LR_FALL_K = 6'd63;
    localparam logic [5:0] LATCH_K   = 6'd63;
    localparam logic [5:0] RESET_K   = 6'd62;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Offset binary to two's complement is an MSB flip; the sample is then
    // left-justified with the dither nibble below it. Mute wins over all.
    function automatic logic [WORD_BITS-1:0] to_i2s_word(
        input logic [SAMPLE_BITS-1:0] sample,
        input logic                   mute,
        input logic [3:0]             dither
    );
        if (mute) begin
            return 16'h0000;
        end else begin
            return {~sample[SAMPLE_BITS-1], sample[SAMPLE_BITS-2:0], dither};
        end
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        if (state[0]) begin
            return (state >> 1) ^ LFSR_TAPS;
        end else begin
            return state >> 1;
        end
    endfunction

endpackage

// File: rtl/wts_i2s_bclk_gen.sv
// wts_i2s_bclk_gen -- divides clk down to the I2S bit clock.
//   clk        in   system clock
//   nreset     in   synchronous active-low reset
//   i2s_bclk   out  bit clock, BCLK_DIV clk per half-period, low after reset
//   fall_tick  out  high during the clk cycle whose closing edge drives
//                   i2s_bclk 1->0, so frame logic clocked on that edge moves
//                   in step with the falling BCLK edge
module wts_i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    output logic i2s_bclk,
    output logic fall_tick
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);

    logic [CW-1:0] div_cnt_r;
    logic [CW-1:0] div_cnt_nx_s;
    logic          bclk_r;
    logic          bclk_nx_s;
    logic          fall_tick_r;

    // Next divider count and bit-clock level.
    always_comb begin
        div_cnt_nx_s = div_cnt_r;
        bclk_nx_s    = bclk_r;
        if (div_cnt_r == TERM) begin
            div_cnt_nx_s = '0;
            bclk_nx_s    = ~bclk_r;
        end else begin
            div_cnt_nx_s = div_cnt_r + CW'(1);
            bclk_nx_s    = bclk_r;
        end
    end

    // Divider state; fall_tick is precomputed from the next state so it is
    // a register yet lines up with the edge that actually drops BCLK.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            div_cnt_r   <= '0;
            bclk_r      <= 1'b0;
            fall_tick_r <= 1'b0;
        end else begin
            div_cnt_r   <= div_cnt_nx_s;
            bclk_r      <= bclk_nx_s;
            fall_tick_r <= (div_cnt_nx_s == TERM) && bclk_nx_s;
        end
    end

    assign i2s_bclk  = bclk_r;
    assign fall_tick = fall_tick_r;

endmodule

// File: rtl/wts_i2s_out.sv
// wts_i2s_out -- Philips I2S transmitter for the wave table sound core.
// Serialises two 12-bit offset-binary channels as 16-bit left-justified
// two's complement words in a 64-BCLK frame.
//   clk           in   system clock (21.47727 MHz)
//   nreset        in   synchronous active-low reset
//   left_in       in   12-bit left sample (offset binary)
//   right_in      in   12-bit right sample (offset binary)
//   mute          in   forces the next latched words to zero
//   i2s_bclk      out  bit clock
//   i2s_lrclk     out  word select, 0 = left, 1 = right
//   i2s_sdata     out  serial data, MSB first
//   frame_strobe  out  one-clk pulse when a new L/R pair is latched
// Optional: define WTS_I2S_DITHER_EN to fill the word low nibbles from a
// 16-bit LFSR instead of zeros.
module wts_i2s_out
    import wts_i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [SAMPLE_BITS-1:0] left_in,
    input  logic [SAMPLE_BITS-1:0] right_in,
    input  logic                   mute,
    output logic                   i2s_bclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdata,
    output logic                   frame_strobe
);

    logic                 fall_tick_s;
    logic [5:0]           k_r;
    logic [5:0]           k_nx_s;
    logic                 latch_s;
    logic                 lrclk_nx_s;
    logic                 sdata_nx_s;
    logic [WORD_BITS-1:0] left_word_r;
    logic [WORD_BITS-1:0] right_word_r;
    logic                 lrclk_r;
    logic                 sdata_r;
    logic                 strobe_r;
    logic [3:0]           dith_l_s;
    logic [3:0]           dith_r_s;

    wts_i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .nreset    (nreset),
        .i2s_bclk  (i2s_bclk),
        .fall_tick (fall_tick_s)
    );

`ifdef WTS_I2S_DITHER_EN
    logic [15:0] lfsr_r;

    // Dither source: current value feeds this latch, then it steps once.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            lfsr_r <= LFSR_SEED;
        end else if (latch_s) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign dith_l_s = lfsr_r[3:0];
    assign dith_r_s = lfsr_r[7:4];
`else
    assign dith_l_s = 4'b0000;
    assign dith_r_s = 4'b0000;
`endif

    // Next bit position and the LRCLK/SDATA levels that belong to it.
    // Both slots map bit k to word[15 - (k mod 16)], i.e. ~k[3:0].
    always_comb begin
        k_nx_s     = k_r + 6'd1;
        latch_s    = fall_tick_s && (k_nx_s == LATCH_K);
        lrclk_nx_s = (k_nx_s >= LR_RISE_K) && (k_nx_s < LR_FALL_K);
        if (k_nx_s[5:4] == 2'b00) begin
            sdata_nx_s = left_word_r[~k_nx_s[3:0]];
        end else if (k_nx_s[5:4] == 2'b10) begin
            sdata_nx_s = right_word_r[~k_nx_s[3:0]];
        end else begin
            sdata_nx_s = 1'b0;
        end
    end

    // Frame state: everything moves only on the BCLK falling edge.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            k_r          <= RESET_K;
            lrclk_r      <= 1'b0;
            sdata_r      <= 1'b0;
            strobe_r     <= 1'b0;
            left_word_r  <= 16'h0000;
            right_word_r <= 16'h0000;
        end else if (fall_tick_s) begin
            k_r      <= k_nx_s;
            lrclk_r  <= lrclk_nx_s;
            sdata_r  <= sdata_nx_s;
            strobe_r <= latch_s;
            if (latch_s) begin
                left_word_r  <= to_i2s_word(left_in, mute, dith_l_s);
                right_word_r <= to_i2s_word(right_in, mute, dith_r_s);
            end else begin
                left_word_r  <= left_word_r;
                right_word_r <= right_word_r;
            end
        end else begin
            k_r          <= k_r;
            lrclk_r      <= lrclk_r;
            sdata_r      <= sdata_r;
            strobe_r     <= 1'b0;
            left_word_r  <= left_word_r;
            right_word_r <= right_word_r;
        end
    end

    assign i2s_lrclk    = lrclk_r;
    assign i2s_sdata    = sdata_r;
    assign frame_strobe = strobe_r;

endmodule

// File: tb/tb_wts_i2s_out.sv
// tb_wts_i2s_out -- directed self-checking bench for wts_i2s_out at
// BCLK_DIV=4: reset state, release timing, frame contents for several
// sample patterns, mid-frame input changes, mute, and mid-frame reset.
module tb_wts_i2s_out;

    logic        clk;
    logic        nreset;
    logic [11:0] left_in;
    logic [11:0] right_in;
    logic        mute;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_strobe;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    logic [15:0] cur_lfsr;
    logic [63:0] lr_exp;
    logic [63:0] zero_mask;

    wts_i2s_out #(.BCLK_DIV(4)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .left_in      (left_in),
        .right_in     (right_in),
        .mute         (mute),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .frame_strobe (frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Bench bookkeeping for each latch: remember the dither value used.
    task automatic note_latch();
        cur_lfsr = m_lfsr;
        m_lfsr   = lfsr_model(m_lfsr);
    endtask

    function automatic logic [3:0] dith(input bit right);
`ifdef WTS_I2S_DITHER_EN
        return right ? cur_lfsr[7:4] : cur_lfsr[3:0];
`else
        return 4'h0;
`endif
    endfunction

    task automatic check_reset_outputs(input string p);
        check_val({p, "_bclk"},   64'(i2s_bclk),     64'd0);
        check_val({p, "_lrclk"},  64'(i2s_lrclk),    64'd0);
        check_val({p, "_sdata"},  64'(i2s_sdata),    64'd0);
        check_val({p, "_strobe"}, 64'(frame_strobe), 64'd0);
    endtask

    // Release reset just after a sampling point; next posedge is cycle 1.
    task automatic release_and_check(input string p);
        nreset = 1'b1;
        m_lfsr = 16'hACE1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 3) check_val({p, "_bclk_c3"}, 64'(i2s_bclk), 64'd0);
            if (c == 4) check_val({p, "_bclk_c4"}, 64'(i2s_bclk), 64'd1);
            if (c == 7) check_val({p, "_strobe_c7"}, 64'(frame_strobe), 64'd0);
            if (c == 8) begin
                check_val({p, "_bclk_c8"}, 64'(i2s_bclk), 64'd0);
                check_val({p, "_strobe_c8"}, 64'(frame_strobe), 64'd1);
            end
        end
        note_latch();
    endtask

    // Capture one frame starting just after a strobe cycle. Fall n is k=n.
    // Inputs nl/nr/nm are applied right after fall chg_k.
    task automatic do_frame(input string f, input int chg_k,
                            input logic [11:0] nl, input logic [11:0] nr, input logic nm,
                            input logic [15:0] el, input logic [15:0] er, input logic emute);
        logic [63:0] lr;
        logic [63:0] sd;
        logic [15:0] lw;
        logic [15:0] rw;
        logic        pb;
        int          falls;
        int          cyc;
        lr = '0; sd = '0; falls = 0; cyc = 0;
        pb = i2s_bclk;
        while (cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (pb && !i2s_bclk) begin
                if (falls < 64) begin
                    lr[falls] = i2s_lrclk;
                    sd[falls] = i2s_sdata;
                end
                if (falls == chg_k) begin
                    left_in = nl; right_in = nr; mute = nm;
                end
                falls++;
            end
            pb = i2s_bclk;
            if (frame_strobe) break;
        end
        for (int i = 0; i < 16; i++) begin
            lw[15-i] = sd[i];
            rw[15-i] = sd[32+i];
        end
        check_val({f, "_left"},   64'(lw), emute ? 64'd0 : 64'(el | {12'h000, dith(1'b0)}));
        check_val({f, "_right"},  64'(rw), emute ? 64'd0 : 64'(er | {12'h000, dith(1'b1)}));
        check_val({f, "_zeros"},  sd & zero_mask, 64'd0);
        check_val({f, "_lrclk"},  lr, lr_exp);
        check_val({f, "_falls"},  64'(falls), 64'd64);
        check_val({f, "_period"}, 64'(cyc), 64'd512);
        note_latch();
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            lr_exp[k]    = (k >= 31 && k <= 62);
            zero_mask[k] = !((k <= 15) || (k >= 32 && k <= 47));
        end
        m_lfsr   = 16'hACE1;
        cur_lfsr = 16'hACE1;
        nreset   = 1'b0;
        left_in  = 12'hFFF;
        right_in = 12'h000;
        mute     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        release_and_check("rel");

        // A: full-scale pair; switch to midscale during the frame.
        do_frame("A", 20, 12'h800, 12'h800, 1'b0, 16'h7FF0, 16'h8000, 1'b0);
        // B: midscale gives an all-zero stream.
        do_frame("B", 20, 12'h123, 12'h800, 1'b0, 16'h0000, 16'h0000, 1'b0);
        // C: latched 12'h123; change at k=5 must not disturb this frame.
        do_frame("C", 5, 12'h456, 12'h800, 1'b0, 16'h9230, 16'h0000, 1'b0);
        // D: new sample shows up in the next frame; arm mute.
        do_frame("D", 20, 12'hFFF, 12'h800, 1'b1, 16'hC560, 16'h0000, 1'b0);
        // E: muted frame; unmute and set full-scale for later.
        do_frame("E", 20, 12'hFFF, 12'h000, 1'b0, 16'h0000, 16'h0000, 1'b1);

        // Reset at k=40 of the next frame.
        begin
            logic pb;
            int   falls;
            int   cyc;
            pb = i2s_bclk; falls = 0; cyc = 0;
            while (falls < 41 && cyc < 600) begin
                @(posedge clk); #1;
                cyc++;
                if (pb && !i2s_bclk) falls++;
                pb = i2s_bclk;
            end
            check_val("k40_reached", 64'(falls), 64'd41);
            check_val("k40_lrclk", 64'(i2s_lrclk), 64'd1);
        end
        nreset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        release_and_check("rel2");
        do_frame("F", 100, 12'hFFF, 12'h000, 1'b0, 16'h7FF0, 16'h8000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
